// File: rtl/lcd_ctrl_param_if.sv
// Command/IROM/IRAM bus of the parametrised LCD image controller.
// The master modport is the controller side; the slave modport is the environment side (ROM, RAM, host).
interface lcd_ctrl_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);
  logic [3:0]        cmd;
  logic              cmd_valid;
  logic              IROM_rd;
  logic [ADDR_W-1:0] IROM_A;
  logic [DATA_W-1:0] IROM_Q;
  logic              IRAM_valid;
  logic [ADDR_W-1:0] IRAM_A;
  logic [DATA_W-1:0] IRAM_D;
  logic              busy;
  logic              done;

  modport master (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
  );

  modport slave (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// LCD image controller: loads an image from IROM, applies 2x2-window commands around a movable
// operation point, then dumps the image to IRAM row-major and pulses done.
module lcd_ctrl_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  lcd_ctrl_param_if.master   bus
);

  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int unsigned XW    = $clog2(IMG_W);
  localparam int unsigned YW    = $clog2(IMG_H);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned SUM_W = DATA_W + 2;

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [3:0] C_WRITE  = 4'h0;
  localparam logic [3:0] C_UP     = 4'h1;
  localparam logic [3:0] C_DOWN   = 4'h2;
  localparam logic [3:0] C_LEFT   = 4'h3;
  localparam logic [3:0] C_RIGHT  = 4'h4;
  localparam logic [3:0] C_MAX    = 4'h5;
  localparam logic [3:0] C_MIN    = 4'h6;
  localparam logic [3:0] C_AVG    = 4'h7;
  localparam logic [3:0] C_CCW    = 4'h8;
  localparam logic [3:0] C_CW     = 4'h9;
  localparam logic [3:0] C_MIRX   = 4'hA;
  localparam logic [3:0] C_MIRY   = 4'hB;
  localparam logic [3:0] C_CENTRE = 4'hC;
  localparam logic [3:0] C_INV    = 4'hD;

  localparam logic [XW-1:0] X_CTR = XW'(IMG_W / 2);
  localparam logic [YW-1:0] Y_CTR = YW'(IMG_H / 2);
  localparam logic [XW-1:0] X_MIN = XW'(1);
  localparam logic [YW-1:0] Y_MIN = YW'(1);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [2:0]        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]        r_cmd, w_cmd_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_irom_rd, w_irom_rd_nxt;
  logic [ADDR_W-1:0] r_irom_a, w_irom_a_nxt;
  logic              r_iram_valid, w_iram_valid_nxt;
  logic [ADDR_W-1:0] r_iram_a, w_iram_a_nxt;
  logic [DATA_W-1:0] r_iram_d, w_iram_d_nxt;
  logic              r_cap_en;
  logic [ADDR_W-1:0] r_cap_a;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [DATA_W-1:0] r_buf [N];

  logic [ADDR_W-1:0] w_cnt_idx;
  logic [XW-1:0]     w_xm;
  logic [YW-1:0]     w_ym;
  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [DATA_W-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [DATA_W-1:0] w_n0, w_n1, w_n2, w_n3;
  logic [DATA_W-1:0] w_max01, w_max23, w_max, w_min01, w_min23, w_min;
  logic [SUM_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_avg;

  assign w_cnt_idx = r_cnt[ADDR_W-1:0];

  // 2x2 window around the operation point; address is {y,x}
  assign w_xm = r_x - XW'(1);
  assign w_ym = r_y - YW'(1);
  assign w_a0 = ADDR_W'({w_ym, w_xm});
  assign w_a1 = ADDR_W'({w_ym, r_x});
  assign w_a2 = ADDR_W'({r_y, w_xm});
  assign w_a3 = ADDR_W'({r_y, r_x});
  assign w_p0 = r_buf[w_a0];
  assign w_p1 = r_buf[w_a1];
  assign w_p2 = r_buf[w_a2];
  assign w_p3 = r_buf[w_a3];

  assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
  assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
  assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
  assign w_min01 = (w_p0 < w_p1) ? w_p0 : w_p1;
  assign w_min23 = (w_p2 < w_p3) ? w_p2 : w_p3;
  assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;
  assign w_sum   = SUM_W'(w_p0) + SUM_W'(w_p1) + SUM_W'(w_p2) + SUM_W'(w_p3);
  assign w_avg   = w_sum[SUM_W-1:2];

  // New window contents, all derived from the pre-command pixels
  always_comb begin
    w_n0 = w_p0;
    w_n1 = w_p1;
    w_n2 = w_p2;
    w_n3 = w_p3;
    case (r_cmd)
      C_MAX:  begin w_n0 = w_max; w_n1 = w_max; w_n2 = w_max; w_n3 = w_max; end
      C_MIN:  begin w_n0 = w_min; w_n1 = w_min; w_n2 = w_min; w_n3 = w_min; end
      C_AVG:  begin w_n0 = w_avg; w_n1 = w_avg; w_n2 = w_avg; w_n3 = w_avg; end
      C_CCW:  begin w_n0 = w_p1; w_n1 = w_p3; w_n3 = w_p2; w_n2 = w_p0; end
      C_CW:   begin w_n0 = w_p2; w_n2 = w_p3; w_n3 = w_p1; w_n1 = w_p0; end
      C_MIRX: begin w_n0 = w_p2; w_n2 = w_p0; w_n1 = w_p3; w_n3 = w_p1; end
      C_MIRY: begin w_n0 = w_p1; w_n1 = w_p0; w_n2 = w_p3; w_n3 = w_p2; end
      C_INV:  begin w_n0 = ~w_p0; w_n1 = ~w_p1; w_n2 = ~w_p2; w_n3 = ~w_p3; end
      default: ;
    endcase
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_cmd_nxt        = r_cmd;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_irom_rd_nxt    = 1'b0;
    w_irom_a_nxt     = r_irom_a;
    w_iram_valid_nxt = 1'b0;
    w_iram_a_nxt     = r_iram_a;
    w_iram_d_nxt     = r_iram_d;
    case (r_state)
      S_LOAD: begin
        if (r_cnt < CNT_W'(N)) begin
          w_irom_rd_nxt = 1'b1;
          w_irom_a_nxt  = w_cnt_idx;
          w_cnt_nxt     = r_cnt + CNT_W'(1);
        end else if (r_cnt == CNT_W'(N)) begin
          // last read issued; wait one cycle for its data to be captured
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_busy_nxt = 1'b1;
          if (bus.cmd == C_WRITE) begin
            w_state_nxt      = S_WRITE;
            w_iram_valid_nxt = 1'b1;
            w_iram_a_nxt     = '0;
            w_iram_d_nxt     = r_buf[0];
            w_cnt_nxt        = CNT_W'(1);
          end else begin
            w_state_nxt = S_EXEC;
            w_cmd_nxt   = bus.cmd;
          end
        end
      end
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      S_WRITE: begin
        if (r_cnt < CNT_W'(N)) begin
          w_iram_valid_nxt = 1'b1;
          w_iram_a_nxt     = w_cnt_idx;
          w_iram_d_nxt     = r_buf[w_cnt_idx];
          w_cnt_nxt        = r_cnt + CNT_W'(1);
        end else begin
          w_state_nxt = S_FIN;
          w_done_nxt  = 1'b1;
        end
      end
      S_FIN: ;
      default: begin
        w_state_nxt = S_LOAD;
        w_busy_nxt  = 1'b1;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_cnt        <= '0;
      r_cmd        <= '0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_irom_rd    <= 1'b0;
      r_irom_a     <= '0;
      r_iram_valid <= 1'b0;
      r_iram_a     <= '0;
      r_iram_d     <= '0;
      r_cap_en     <= 1'b0;
      r_cap_a      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cmd        <= w_cmd_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_irom_rd    <= w_irom_rd_nxt;
      r_irom_a     <= w_irom_a_nxt;
      r_iram_valid <= w_iram_valid_nxt;
      r_iram_a     <= w_iram_a_nxt;
      r_iram_d     <= w_iram_d_nxt;
      r_cap_en     <= r_irom_rd;
      r_cap_a      <= r_irom_a;
    end
  end

  // Operation point: clamps at the window range limits, no wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= X_CTR;
      r_y <= Y_CTR;
    end else if (r_state == S_EXEC) begin
      case (r_cmd)
        C_UP:     if (r_y > Y_MIN) r_y <= r_y - YW'(1);
        C_DOWN:   if (r_y < Y_MAX) r_y <= r_y + YW'(1);
        C_LEFT:   if (r_x > X_MIN) r_x <= r_x - XW'(1);
        C_RIGHT:  if (r_x < X_MAX) r_x <= r_x + XW'(1);
        C_CENTRE: begin r_x <= X_CTR; r_y <= Y_CTR; end
        default: ;
      endcase
    end
  end

  // Image buffer: filled one cycle behind each IROM read, rewritten by window commands
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && r_cap_en) begin
      r_buf[r_cap_a] <= bus.IROM_Q;
    end else if (r_state == S_EXEC) begin
      r_buf[w_a0] <= w_n0;
      r_buf[w_a1] <= w_n1;
      r_buf[w_a2] <= w_n2;
      r_buf[w_a3] <= w_n3;
    end
  end

  assign bus.IROM_rd    = r_irom_rd;
  assign bus.IROM_A     = r_irom_a;
  assign bus.IRAM_valid = r_iram_valid;
  assign bus.IRAM_A     = r_iram_a;
  assign bus.IRAM_D     = r_iram_d;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: 8x8x8 instance driven from a vector table plus corner sequences,
// and a 16x4x10 instance for the wide-pixel average and row-major dump order.
module tb_lcd_ctrl_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.DATA_W(8),  .ADDR_W(6)) b1();
  lcd_ctrl_param_if #(.DATA_W(10), .ADDR_W(6)) b2();

  lcd_ctrl_param #(.DATA_W(8), .IMG_W(8), .IMG_H(8), .ADDR_W(6)) u_dut (
    .clk(clk), .reset(rst_n), .bus(b1));
  lcd_ctrl_param #(.DATA_W(10), .IMG_W(16), .IMG_H(4), .ADDR_W(6)) u_dut2 (
    .clk(clk), .reset(rst2_n), .bus(b2));

  typedef struct packed { logic [5:0] a; logic [15:0] d; } exp_t;
  typedef struct { int kind; int ncmd; logic [63:0] cmds; int ex; int ey; int e0; int e1; int e2; int e3; } vec_t;

  logic [7:0] rom1 [64];
  logic [9:0] rom2 [64];
  exp_t q1[$];
  exp_t q2[$];
  exp_t m1, m2;
  int checks = 0, failures = 0;
  int vcnt1 = 0, dcnt1 = 0, vcnt2 = 0, dcnt2 = 0;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
    end
  endtask

  always @(posedge clk) begin
    if (b1.IROM_rd) b1.IROM_Q <= rom1[b1.IROM_A];
    if (b2.IROM_rd) b2.IROM_Q <= rom2[b2.IROM_A];
  end

  // IRAM scoreboards
  always @(negedge clk) begin
    if (b1.IRAM_valid === 1'b1) begin
      vcnt1++;
      if (q1.size() == 0) chk("iram1_unexpected_write", 1, 0);
      else begin
        m1 = q1.pop_front();
        chk("iram1_addr", 32'(b1.IRAM_A), 32'(m1.a));
        chk("iram1_data", 32'(b1.IRAM_D), 32'(m1.d));
      end
    end
    if (b1.done === 1'b1) dcnt1++;
    if (b2.IRAM_valid === 1'b1) begin
      vcnt2++;
      if (q2.size() == 0) chk("iram2_unexpected_write", 1, 0);
      else begin
        m2 = q2.pop_front();
        chk("iram2_addr", 32'(b2.IRAM_A), 32'(m2.a));
        chk("iram2_data", 32'(b2.IRAM_D), 32'(m2.d));
      end
    end
    if (b2.done === 1'b1) dcnt2++;
  end

  task automatic build_img(input int kind);
    for (int i = 0; i < 64; i++) rom1[i] = 8'(i);
    if (kind == 1) begin rom1[27] = 8'd10; rom1[28] = 8'd20; rom1[35] = 8'd30; rom1[36] = 8'd40; end
    if (kind == 2) begin rom1[27] = 8'd1;  rom1[28] = 8'd2;  rom1[35] = 8'd3;  rom1[36] = 8'd4;  end
  endtask

  // Reset mid-cycle, check reset outputs, release, then check the full load sequence
  task automatic do_reset1();
    int n;
    int rd;
    @(posedge clk);
    #2 rst_n = 1'b0;
    b1.cmd_valid = 1'b0;
    #1;
    chk("rst_busy", 32'(b1.busy), 1);
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_irom_rd", 32'(b1.IROM_rd), 0);
    chk("rst_irom_a", 32'(b1.IROM_A), 0);
    chk("rst_iram_valid", 32'(b1.IRAM_valid), 0);
    chk("rst_iram_a", 32'(b1.IRAM_A), 0);
    chk("rst_iram_d", 32'(b1.IRAM_D), 0);
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    rd = 0;
    do begin
      @(negedge clk);
      n++;
      if (b1.IROM_rd === 1'b1) begin
        chk("irom_addr", 32'(b1.IROM_A), 32'(rd));
        rd++;
      end
    end while (b1.busy !== 1'b0 && n < 200);
    chk("load_rd_cycles", 32'(rd), 64);
    chk("load_latency", 32'(n), 66);
  endtask

  task automatic issue1(input logic [3:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (b1.busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cmd1_wait_idle_timeout", 1, 0);
    b1.cmd = c;
    b1.cmd_valid = 1'b1;
    @(negedge clk);
    b1.cmd_valid = 1'b0;
    chk("busy_after_accept", 32'(b1.busy), 1);
  endtask

  task automatic issue2(input logic [3:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (b2.busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("cmd2_wait_idle_timeout", 1, 0);
    b2.cmd = c;
    b2.cmd_valid = 1'b1;
    @(negedge clk);
    b2.cmd_valid = 1'b0;
    chk("busy2_after_accept", 32'(b2.busy), 1);
  endtask

  // Expected image = loaded image with the window at (ex,ey) overridden; then dump and check
  task automatic dump1(input int ex, input int ey, input int e0, input int e1, input int e2, input int e3);
    logic [7:0] img [64];
    int a0;
    int n;
    for (int i = 0; i < 64; i++) img[i] = rom1[i];
    a0 = (ey - 1) * 8 + (ex - 1);
    img[a0] = 8'(e0); img[a0 + 1] = 8'(e1); img[a0 + 8] = 8'(e2); img[a0 + 9] = 8'(e3);
    for (int i = 0; i < 64; i++) q1.push_back('{a: 6'(i), d: 16'(img[i])});
    vcnt1 = 0;
    dcnt1 = 0;
    issue1(4'h0);
    n = 0;
    while (dcnt1 == 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("done1_timeout", 1, 0);
    repeat (3) @(negedge clk);
    chk("write_valid_cycles", 32'(vcnt1), 64);
    chk("done_pulses", 32'(dcnt1), 1);
    chk("queue_drained", 32'(q1.size()), 0);
    chk("fin_busy", 32'(b1.busy), 1);
    chk("fin_iram_valid", 32'(b1.IRAM_valid), 0);
    q1.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] cl;
    logic [9:0] img2 [64];
    int n;
    b1.cmd = 4'h0; b1.cmd_valid = 1'b0;
    b2.cmd = 4'h0; b2.cmd_valid = 1'b0;

    //        kind ncmd cmds                  ex ey  e0   e1   e2   e3
    vecs[0]  = '{0, 0,  64'h0,                4, 4,  27,  28,  35,  36};
    vecs[1]  = '{1, 1,  64'h5,                4, 4,  40,  40,  40,  40};
    vecs[2]  = '{1, 1,  64'h7,                4, 4,  25,  25,  25,  25};
    vecs[3]  = '{1, 2,  64'hD7,               4, 4,  230, 230, 230, 230};
    vecs[4]  = '{1, 1,  64'h6,                4, 4,  10,  10,  10,  10};
    vecs[5]  = '{2, 1,  64'h8,                4, 4,  2,   4,   1,   3};
    vecs[6]  = '{2, 2,  64'h98,               4, 4,  1,   2,   3,   4};
    vecs[7]  = '{2, 1,  64'hA,                4, 4,  3,   4,   1,   2};
    vecs[8]  = '{2, 2,  64'hBA,               4, 4,  4,   3,   2,   1};
    vecs[9]  = '{1, 1,  64'hD,                4, 4,  245, 235, 225, 215};
    vecs[10] = '{0, 15, 64'h511111113333333,  1, 1,  9,   9,   9,   9};
    vecs[11] = '{0, 16, 64'h5C11111113333333, 4, 4,  36,  36,  36,  36};
    vecs[12] = '{0, 15, 64'h622222224444444,  7, 7,  54,  54,  54,  54};
    vecs[13] = '{2, 4,  64'h12FE,             4, 4,  1,   2,   3,   4};

    for (int k = 0; k < 14; k++) begin
      build_img(vecs[k].kind);
      do_reset1();
      cl = vecs[k].cmds;
      for (int j = 0; j < vecs[k].ncmd; j++) issue1(cl[4*j +: 4]);
      dump1(vecs[k].ex, vecs[k].ey, vecs[k].e0, vecs[k].e1, vecs[k].e2, vecs[k].e3);
    end

    // cmd_valid held across the busy cycle: only the first RIGHT is taken
    build_img(0);
    do_reset1();
    @(negedge clk);
    b1.cmd = 4'h4;
    b1.cmd_valid = 1'b1;
    @(negedge clk);
    chk("held_valid_busy_high", 32'(b1.busy), 1);
    @(negedge clk);
    chk("held_valid_busy_low", 32'(b1.busy), 0);
    b1.cmd_valid = 1'b0;
    issue1(4'h6);
    dump1(5, 4, 28, 28, 28, 28);

    // reset in the middle of the IRAM dump, then a fresh load of a different image
    build_img(0);
    do_reset1();
    for (int i = 0; i < 64; i++) q1.push_back('{a: 6'(i), d: 16'(i)});
    vcnt1 = 0;
    dcnt1 = 0;
    issue1(4'h0);
    repeat (10) @(negedge clk);
    build_img(1);
    do_reset1();
    chk("abort_no_done", 32'(dcnt1), 0);
    issue1(4'h5);
    dump1(4, 4, 40, 40, 40, 40);

    // 16x4 image with 10-bit pixels, op point (8,2)
    for (int i = 0; i < 64; i++) rom2[i] = 10'(i);
    rom2[23] = 10'd1023; rom2[24] = 10'd1023; rom2[39] = 10'd1023; rom2[40] = 10'd1022;
    chk("rst2_busy", 32'(b2.busy), 1);
    chk("rst2_irom_rd", 32'(b2.IROM_rd), 0);
    chk("rst2_iram_valid", 32'(b2.IRAM_valid), 0);
    chk("rst2_done", 32'(b2.done), 0);
    @(negedge clk);
    rst2_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (b2.busy !== 1'b0 && n < 200);
    chk("load2_latency", 32'(n), 66);
    issue2(4'h7);
    for (int i = 0; i < 64; i++) img2[i] = rom2[i];
    img2[23] = 10'd1022; img2[24] = 10'd1022; img2[39] = 10'd1022; img2[40] = 10'd1022;
    for (int i = 0; i < 64; i++) q2.push_back('{a: 6'(i), d: 16'(img2[i])});
    vcnt2 = 0;
    dcnt2 = 0;
    issue2(4'h0);
    n = 0;
    while (dcnt2 == 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("done2_timeout", 1, 0);
    repeat (3) @(negedge clk);
    chk("write2_valid_cycles", 32'(vcnt2), 64);
    chk("done2_pulses", 32'(dcnt2), 1);
    chk("queue2_drained", 32'(q2.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
